// File: rtl/branch_predictor_table.sv
// -----------------------------------------------------------------------------
// branch_predictor_table
//
// This module is a branch predictor built from a table of ENTRIES saturating
// counters, each CTR_WIDTH bits wide.
//
// Indexing is bimodal when HIST_BITS = 0. In that mode the index is
// pc[IDX_BITS+1:2]. When HIST_BITS > 0 the predictor uses gshare: that same PC
// slice is XORed with a zero-extended global history register (ghr). The ghr
// shifts in each resolved outcome.
//
// After reset the table runs an INIT sweep. The sweep writes the weakly
// not-taken value 2^(CTR_WIDTH-1)-1 into one entry per cycle. Once every entry
// has been written, the table enters READY and stays there until the next
// reset. Because the sweep rewrites the whole array, the counters themselves
// have no reset.
//
// Optional build macro:
//   BP_PERF_CNT_EN  adds two 32-bit counters, perf_branches and
//                   perf_mispredicts.
//
// Ports:
//   clk               clock; all state changes on the rising edge
//   rst_n             asynchronous active-low reset
//   lookup_valid      decode-stage instruction is a branch
//   lookup_pc         PC of the decode-stage branch
//   lookup_offset     sign-extended branch immediate
//   predict           predict taken (combinational)
//   branch_addr       lookup_pc + lookup_offset, modulo 2^32 (combinational)
//   ready             table initialised
//   update_valid      a branch resolved in the memory stage
//   update_pc         PC of the resolved branch
//   update_taken      actual outcome of the resolved branch
//   update_predicted  prediction that travelled down the pipeline
//   perf_branches     (BP_PERF_CNT_EN only) resolved branches seen in READY
//   perf_mispredicts  (BP_PERF_CNT_EN only) mispredictions seen in READY
// -----------------------------------------------------------------------------
module branch_predictor_table #(
    parameter int ENTRIES   = 64,
    parameter int CTR_WIDTH = 2,
    parameter int HIST_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_offset,
    output logic        predict,
    output logic [31:0] branch_addr,
    output logic        ready,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic        update_predicted
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int GHR_W    = (HIST_BITS > 0) ? HIST_BITS : 1;

    localparam logic [CTR_WIDTH-1:0] INIT_VAL = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_ZERO = '0;
    localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [IDX_BITS-1:0]   init_idx;
    logic [CTR_WIDTH-1:0]  ctr_table [ENTRIES];

    logic [IDX_BITS-1:0]   hist_term;
    logic [IDX_BITS-1:0]   lookup_idx;
    logic [IDX_BITS-1:0]   update_idx;
    logic [CTR_WIDTH-1:0]  update_ctr;
    logic                  update_fire;

    logic                  tbl_we;
    logic [IDX_BITS-1:0]   tbl_widx;
    logic [CTR_WIDTH-1:0]  tbl_wdata;

    // Resolutions that arrive during the INIT sweep are dropped entirely.
    // They change neither a counter nor the history.
    assign update_fire = (state == ST_READY) && update_valid;

    // History term. The bimodal build has no history register at all.
    // The gshare build shifts the resolved outcome into the LSB. The explicit
    // cast keeps only the low GHR_W bits, so HIST_BITS = 1 degenerates to
    // ghr <= update_taken.
    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign hist_term = '0;
        end else begin : g_gshare
            logic [GHR_W-1:0] ghr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr <= '0;
                end else if (update_fire) begin
                    ghr <= GHR_W'({ghr, update_taken});
                end
            end

            assign hist_term = IDX_BITS'(ghr);
        end
    endgenerate

    // Both indices use the current ghr. An update therefore indexes with the
    // history as it was before its own shift.
    assign lookup_idx = lookup_pc[IDX_BITS+1:2] ^ hist_term;
    assign update_idx = update_pc[IDX_BITS+1:2] ^ hist_term;
    assign update_ctr = ctr_table[update_idx];

    assign ready       = (state == ST_READY);
    assign branch_addr = lookup_pc + lookup_offset;

    // The lookup reads the registered array directly, so a same-cycle update
    // to the same entry only becomes visible on the following cycle.
    assign predict = lookup_valid && ready && ctr_table[lookup_idx][CTR_WIDTH-1];

    // State register and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state <= next_state;
            if (state == ST_INIT) begin
                init_idx <= init_idx + IDX_BITS'(1);
            end
        end
    end

    // Next-state and table write port. In INIT the write port is owned by the
    // sweep. In READY it is owned by the resolving branch. A saturated counter
    // produces no write.
    always_comb begin
        next_state = state;
        tbl_we     = 1'b0;
        tbl_widx   = init_idx;
        tbl_wdata  = INIT_VAL;
        case (state)
            ST_INIT: begin
                tbl_we = 1'b1;
                if (init_idx == LAST_IDX) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                tbl_widx = update_idx;
                if (update_fire) begin
                    if (update_taken && (update_ctr != CTR_MAX)) begin
                        tbl_we    = 1'b1;
                        tbl_wdata = update_ctr + CTR_WIDTH'(1);
                    end else if (!update_taken && (update_ctr != CTR_ZERO)) begin
                        tbl_we    = 1'b1;
                        tbl_wdata = update_ctr - CTR_WIDTH'(1);
                    end
                end
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    // Counter array. It has deliberately no reset, because the INIT sweep
    // defines every entry before any prediction is allowed through.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            ctr_table[tbl_widx] <= tbl_wdata;
        end
    end

`ifdef BP_PERF_CNT_EN
    // Performance counters. They count only resolutions accepted in READY
    // and wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (update_fire) begin
            perf_branches <= perf_branches + 32'd1;
            if (update_taken != update_predicted) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

    // These PC bits never take part in indexing. In the default build the
    // carried prediction has no consumer.
    logic unused_bits;
    assign unused_bits = &{1'b0, update_pc[31:IDX_BITS+2], update_pc[1:0], update_predicted};

endmodule

// File: tb/tb_branch_predictor_table.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_table
//
// This bench drives two predictor instances with shared stimulus:
//   dut0: the default bimodal configuration (64 entries, 2-bit counters).
//   dut1: a gshare configuration (16 entries, 3-bit counters, 2 history bits).
//
// A reference model held in plain integer arrays predicts every combinational
// output before each rising edge. It then applies the table and history rules
// at that edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor_table;

    localparam int E0 = 64;
    localparam int W0 = 2;
    localparam int E1 = 16;
    localparam int W1 = 3;
    localparam int H1 = 2;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_offset;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_predicted;

    logic        predict0;
    logic        predict1;
    logic [31:0] branch_addr0;
    logic [31:0] branch_addr1;
    logic        ready0;
    logic        ready1;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br0;
    logic [31:0] perf_mp0;
    logic [31:0] perf_br1;
    logic [31:0] perf_mp1;
`endif

    branch_predictor_table #(.ENTRIES(E0), .CTR_WIDTH(W0), .HIST_BITS(0)) dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .lookup_offset    (lookup_offset),
        .predict          (predict0),
        .branch_addr      (branch_addr0),
        .ready            (ready0),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_predicted (update_predicted)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches    (perf_br0),
        .perf_mispredicts (perf_mp0)
`endif
    );

    branch_predictor_table #(.ENTRIES(E1), .CTR_WIDTH(W1), .HIST_BITS(H1)) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .lookup_offset    (lookup_offset),
        .predict          (predict1),
        .branch_addr      (branch_addr1),
        .ready            (ready1),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_predicted (update_predicted)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches    (perf_br1),
        .perf_mispredicts (perf_mp1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state.
    int m0 [E0];
    int m1 [E1];
    int ghr1;
    int edges_since_release;
    int pb0, pm0, pb1, pm1;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int idx0(input logic [31:0] pc);
        return int'((pc >> 2) % E0);
    endfunction

    function automatic int idx1(input logic [31:0] pc, input int h);
        return int'((pc >> 2) % E1) ^ h;
    endfunction

    function automatic int bump(input int v, input bit taken, input int width);
        int maxv;
        maxv = (1 << width) - 1;
        if (taken) return (v < maxv) ? v + 1 : v;
        return (v > 0) ? v - 1 : v;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        logic [5:0]  slot;
        p      = $urandom;
        slot   = 6'($urandom_range(0, 7));
        p[7:2] = slot;
        return p;
    endfunction

    task automatic model_reset();
        edges_since_release = 0;
        ghr1 = 0;
        pb0 = 0; pm0 = 0; pb1 = 0; pm1 = 0;
    endtask

    // Applies the table, history and performance rules for one rising edge.
    // The sweep is modelled only by its outcome: once a table has been swept,
    // every entry holds the weakly not-taken value.
    task automatic model_edge();
        bit r0, r1;
        int i;
        r0 = (edges_since_release >= E0);
        r1 = (edges_since_release >= E1);
        if (update_valid) begin
            if (r0) begin
                i = idx0(update_pc);
                m0[i] = bump(m0[i], update_taken, W0);
                pb0++;
                if (update_taken != update_predicted) pm0++;
            end
            if (r1) begin
                i = idx1(update_pc, ghr1);
                m1[i] = bump(m1[i], update_taken, W1);
                ghr1 = ((ghr1 << 1) | int'(update_taken)) % (1 << H1);
                pb1++;
                if (update_taken != update_predicted) pm1++;
            end
        end
        if (edges_since_release < E0) begin
            edges_since_release++;
            if (edges_since_release == E1) foreach (m1[k]) m1[k] = (1 << (W1 - 1)) - 1;
            if (edges_since_release == E0) foreach (m0[k]) m0[k] = (1 << (W0 - 1)) - 1;
        end
    endtask

    // One cycle: drive on the falling edge, check outputs shortly afterwards,
    // then let the rising edge happen and advance the model.
    task automatic apply_stimulus(input bit rst, input bit lv, input logic [31:0] lpc,
                                  input logic [31:0] loff, input bit uv,
                                  input logic [31:0] upc, input bit ut, input bit up);
        bit r0, r1, e0, e1;
        @(negedge clk);
        rst_n            = rst;
        lookup_valid     = lv;
        lookup_pc        = lpc;
        lookup_offset    = loff;
        update_valid     = uv;
        update_pc        = upc;
        update_taken     = ut;
        update_predicted = up;
        if (!rst) model_reset();
        #1;
        r0 = (edges_since_release >= E0);
        r1 = (edges_since_release >= E1);
        e0 = lv && r0 && (m0[idx0(lpc)] >= (1 << (W0 - 1)));
        e1 = lv && r1 && (m1[idx1(lpc, ghr1)] >= (1 << (W1 - 1)));
        check_output("ready0", 32'(ready0), 32'(r0));
        check_output("ready1", 32'(ready1), 32'(r1));
        check_output("predict0", 32'(predict0), 32'(e0));
        check_output("predict1", 32'(predict1), 32'(e1));
        check_output("branch_addr0", branch_addr0, lpc + loff);
        check_output("branch_addr1", branch_addr1, lpc + loff);
`ifdef BP_PERF_CNT_EN
        check_output("perf_branches0", perf_br0, 32'(pb0));
        check_output("perf_mispredicts0", perf_mp0, 32'(pm0));
        check_output("perf_branches1", perf_br1, 32'(pb1));
        check_output("perf_mispredicts1", perf_mp1, 32'(pm1));
`endif
        @(posedge clk);
        if (rst) model_edge();
    endtask

    task automatic random_cycle(input bit rst);
        logic [31:0] upc;
        logic [31:0] lpc;
        upc = rand_pc();
        lpc = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
        apply_stimulus(rst, 1'($urandom), lpc, $urandom, 1'($urandom), upc,
                       1'($urandom), 1'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; lookup_offset = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_predicted = 1'b0;
        model_reset();

        // Reset held, then the full sweep with random traffic that must be ignored.
        repeat (3) random_cycle(1'b0);
        repeat (E0) random_cycle(1'b1);

        // First lookup after init, with a negative offset.
        apply_stimulus(1, 1, 32'h100, 32'hFFFF_FFF0, 0, 32'h0, 0, 0);
        check_output("addr_neg_offset", branch_addr0, 32'h0000_00F0);

        // Saturate up, then saturate down, on pc 0x100.
        repeat (4) apply_stimulus(1, 1, 32'h100, 32'h8, 1, 32'h100, 1, 0);
        repeat (5) apply_stimulus(1, 1, 32'h100, 32'h8, 1, 32'h100, 0, 1);
        apply_stimulus(1, 1, 32'h100, 32'h8, 0, 32'h0, 0, 0);

        // Same-cycle lookup and taken update on pc 0x200 with the counter at 1.
        apply_stimulus(1, 0, 32'h0, 32'h0, 1, 32'h200, 1, 0);
        apply_stimulus(1, 1, 32'h200, 32'h4, 1, 32'h200, 1, 0);
        apply_stimulus(1, 1, 32'h200, 32'h4, 0, 32'h0, 0, 0);

        // History-steered indexing: two taken resolutions, then pc 0x0 traffic.
        repeat (2) apply_stimulus(1, 0, 32'h0, 32'h0, 1, 32'h40, 1, 1);
        repeat (3) apply_stimulus(1, 1, 32'h0, 32'h0, 1, 32'h0, 1, 1);
        apply_stimulus(1, 1, 32'h0, 32'h0, 0, 32'h0, 0, 0);

        // Random traffic in READY.
        repeat (1500) random_cycle(1'b1);

        // Reset mid-READY, release, then reset again mid-sweep at init_idx 30.
        repeat (2) random_cycle(1'b0);
        repeat (30) random_cycle(1'b1);
        repeat (2) random_cycle(1'b0);
        repeat (E0 + 4) random_cycle(1'b1);

        repeat (500) random_cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
